fetch_align_buffer: RTL and testbench

Halfword-granular instruction fetch buffer between the word-addressed instruction memory port and the decompression stage. It issues word-aligned fetches, keeps up to four 16-bit parcels, and presents one aligned instruction per handshake. A presented instruction is either a 16-bit compressed parcel (zero-extended) or a 32-bit instruction, which may straddle a word boundary. Taken branches and jumps from EX redirect it through a flush input.

---
 rtl/fetch_align_buffer.sv | 144 ++++++++++++++
 tb/tb_fetch_align_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// rtl/fetch_align_buffer.sv - halfword-granular instruction fetch and alignment buffer
//
// Issues word-aligned fetches, queues up to four 16-bit parcels and presents
// one aligned instruction (compressed or 32-bit, possibly straddling a word)
// per downstream handshake. A redirect flushes the queue and restarts fetch.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect, redirect_pc     flush and restart fetch at redirect_pc (bit 0 ignored)
//   mem_req, mem_addr         word-aligned fetch request
//   mem_ready                 memory accepts the request this cycle
//   mem_rvalid, mem_rdata     read data, one cycle after an accepted request
//   out_valid, out_ready      instruction handshake to the decompression stage
//   out_inst, out_pc          aligned instruction and its address
//   out_is_comp               instruction is a 16-bit compressed parcel

module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_is_comp
);

    logic [15:0] q        [4];
    logic [15:0] q_shift  [4];
    logic [15:0] q_next   [4];
    logic [2:0]  count;
    logic [2:0]  cnt_pop;
    logic [2:0]  cnt_next;
    logic [31:0] head_pc;
    logic [29:0] fetch_word;
    logic        inflight;
    logic        skip_low;
    logic        discard;

    logic        hw0_comp;
    logic        fire;
    logic        pop;
    logic        append;
    logic [3:0]  credit;

    always_comb begin
        hw0_comp    = (q[0][1:0] != 2'b11);
        out_valid   = !rst && (((count >= 3'd1) && hw0_comp) ||
                               ((count >= 3'd2) && !hw0_comp));
        out_inst    = hw0_comp ? {16'h0000, q[0]} : {q[1], q[0]};
        out_pc      = head_pc;
        out_is_comp = hw0_comp;

        // An outstanding word is reserved as two parcels; a same-cycle pop
        // earns no credit, so the queue can never overflow.
        credit      = {1'b0, count} + {2'b00, inflight, 1'b0};
        mem_req     = !redirect && !rst && (credit <= 4'd2);
        mem_addr    = {fetch_word, 2'b00};

        fire        = mem_req && mem_ready;
        pop         = out_valid && out_ready;
        append      = mem_rvalid && !discard;
    end

    // Pop stage: drop the consumed parcels from the head.
    always_comb begin
        q_shift = q;
        cnt_pop = count;
        if (pop && hw0_comp) begin
            q_shift[0] = q[1];
            q_shift[1] = q[2];
            q_shift[2] = q[3];
            q_shift[3] = 16'h0000;
            cnt_pop    = count - 3'd1;
        end else if (pop) begin
            q_shift[0] = q[2];
            q_shift[1] = q[3];
            q_shift[2] = 16'h0000;
            q_shift[3] = 16'h0000;
            cnt_pop    = count - 3'd2;
        end
    end

    // Append stage: land the returned word behind whatever survived the pop.
    // After a redirect to an odd halfword only the upper parcel is kept.
    always_comb begin
        q_next   = q_shift;
        cnt_next = cnt_pop;
        if (append) begin
            if (skip_low) begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) == cnt_pop) q_next[i] = mem_rdata[31:16];
                end
                cnt_next = cnt_pop + 3'd1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) == cnt_pop)
                        q_next[i] = mem_rdata[15:0];
                    else if (3'(i) == cnt_pop + 3'd1)
                        q_next[i] = mem_rdata[31:16];
                end
                cnt_next = cnt_pop + 3'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i] <= 16'h0000;
            count      <= 3'd0;
            head_pc    <= RESET_PC;
            fetch_word <= RESET_PC[31:2];
            inflight   <= 1'b0;
            skip_low   <= RESET_PC[1];
            discard    <= 1'b0;
        end else if (redirect) begin
            count      <= 3'd0;
            head_pc    <= redirect_pc & ~32'h1;
            fetch_word <= redirect_pc[31:2];
            skip_low   <= redirect_pc[1];
            // A response landing in the redirect cycle is dropped with the
            // flush; only a response still owed afterwards must be discarded.
            inflight   <= inflight && !mem_rvalid;
            discard    <= inflight && !mem_rvalid;
        end else begin
            q        <= q_next;
            count    <= cnt_next;
            if (pop) head_pc <= head_pc + (hw0_comp ? 32'd2 : 32'd4);
            if (fire) fetch_word <= fetch_word + 30'd1;
            inflight <= fire || (inflight && !mem_rvalid);
            if (mem_rvalid) discard <= 1'b0;
            if (append) skip_low <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb/tb_fetch_align_buffer.sv - self-checking bench for fetch_align_buffer

module tb_fetch_align_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_comp;

    always #5 clk = ~clk;

    fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_is_comp (out_is_comp)
    );

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        logic        redir;
        logic [31:0] start;
        int          lat;
        logic [31:0] pc0, inst0;
        logic        c0;
        logic [31:0] pc1, inst1;
        logic        c1;
    } vec_t;

    vec_t        vecs [5];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [64];
    logic [31:0] exp_pc;
    int          pops;
    int          log_base;
    logic [31:0] lp_pc   [2];
    logic [31:0] lp_inst [2];
    logic        lp_comp [2];
    logic        s_req, s_valid;
    logic [31:0] s_addr;
    logic        prev_hold, prev_stall;
    logic [31:0] h_inst, h_pc, h_addr;
    logic        h_comp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // One clock cycle: sample and check away from the edge, advance the
    // reference PC on every accepted instruction, then play the memory.
    task automatic cycle();
        logic [15:0] h0;
        logic        comp;
        logic [31:0] ei;
        logic        fire;
        @(negedge clk);
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = out_valid;
        fire    = mem_req && mem_ready;
        if (rst) begin
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
            exp_pc     = 32'h0;
            prev_hold  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (mem_req) chk("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
            if (redirect) chk("req_gated", {31'b0, mem_req}, 32'd0);
            if (prev_hold) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_inst", out_inst, h_inst);
                chk("hold_pc", out_pc, h_pc);
                chk("hold_comp", {31'b0, out_is_comp}, {31'b0, h_comp});
            end
            if (prev_stall && !redirect) begin
                chk("stall_req", {31'b0, mem_req}, 32'd1);
                chk("stall_addr", mem_addr, h_addr);
            end
            if (out_valid && out_ready) begin
                h0   = hw_at(exp_pc);
                comp = (h0[1:0] != 2'b11);
                ei   = comp ? {16'h0000, h0} : {hw_at(exp_pc + 32'd2), h0};
                chk("pop_pc", out_pc, exp_pc);
                chk("pop_inst", out_inst, ei);
                chk("pop_comp", {31'b0, out_is_comp}, {31'b0, comp});
                if (pops >= log_base && pops - log_base < 2) begin
                    lp_pc[pops - log_base]   = out_pc;
                    lp_inst[pops - log_base] = out_inst;
                    lp_comp[pops - log_base] = out_is_comp;
                end
                pops++;
                exp_pc = exp_pc + (comp ? 32'd2 : 32'd4);
            end
            prev_hold  = out_valid && !out_ready && !redirect;
            h_inst     = out_inst;
            h_pc       = out_pc;
            h_comp     = out_is_comp;
            prev_stall = mem_req && !mem_ready;
            h_addr     = mem_addr;
            if (redirect) exp_pc = redirect_pc & ~32'h1;
        end
        @(posedge clk);
        #1;
        mem_rvalid = fire;
        mem_rdata  = fire ? mem[s_addr[7:2]] : $urandom();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int first, idx, cnt, base;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        mem_ready = 1'b1; out_ready = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        pops = 0; log_base = 0; exp_pc = 32'h0;
        prev_hold = 1'b0; prev_stall = 1'b0;
        h_inst = 32'h0; h_pc = 32'h0; h_addr = 32'h0; h_comp = 1'b0;

        vecs[0] = '{32'h00A00093, 32'h00100113, 32'h0, 32'h0, 1'b0, 32'h0, 2,
                    32'h0, 32'h00A00093, 1'b0, 32'h4, 32'h00100113, 1'b0};
        vecs[1] = '{32'h45054501, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2,
                    32'h0, 32'h00004501, 1'b1, 32'h2, 32'h00004505, 1'b1};
        vecs[2] = '{32'h00934501, 32'h000000A0, 32'h0, 32'h0, 1'b0, 32'h0, 2,
                    32'h0, 32'h00004501, 1'b1, 32'h2, 32'h00A00093, 1'b0};
        vecs[3] = '{32'h0, 32'h00931234, 32'h450500A0, 32'h0, 1'b1, 32'h6, 0,
                    32'h6, 32'h00A00093, 1'b0, 32'hA, 32'h00004505, 1'b1};
        vecs[4] = '{32'h0, 32'h4501FFFF, 32'h01130093, 32'h0, 1'b1, 32'h6, 3,
                    32'h6, 32'h00004501, 1'b1, 32'h8, 32'h01130093, 1'b0};

        for (int v = 0; v < 5; v++) begin
            fill_random();
            mem[0] = vecs[v].w0; mem[1] = vecs[v].w1;
            mem[2] = vecs[v].w2; mem[3] = vecs[v].w3;
            out_ready = 1'b1; mem_ready = 1'b1;
            do_reset();
            if (vecs[v].redir) begin
                cycle();
                redirect = 1'b1;
                redirect_pc = vecs[v].start;
                cycle();
                chk("redir_req_low", {31'b0, s_req}, 32'd0);
                redirect = 1'b0;
            end
            log_base = pops;
            first = -1;
            idx = vecs[v].redir ? 1 : 0;
            cnt = 0;
            while (pops - log_base < 2 && cnt < 40) begin
                cycle();
                if (cnt == 0) begin
                    chk("first_req", {31'b0, s_req}, 32'd1);
                    chk("first_addr", s_addr, vecs[v].start & ~32'h3);
                end
                if (s_valid && first < 0) first = idx;
                idx++;
                cnt++;
            end
            chk("vec_two_pops", {31'b0, (pops - log_base >= 2)}, 32'd1);
            chk("vec_pc0", lp_pc[0], vecs[v].pc0);
            chk("vec_inst0", lp_inst[0], vecs[v].inst0);
            chk("vec_comp0", {31'b0, lp_comp[0]}, {31'b0, vecs[v].c0});
            chk("vec_pc1", lp_pc[1], vecs[v].pc1);
            chk("vec_inst1", lp_inst[1], vecs[v].inst1);
            chk("vec_comp1", {31'b0, lp_comp[1]}, {31'b0, vecs[v].c1});
            if (vecs[v].lat != 0) chk("latency", first, vecs[v].lat);
        end

        // Backpressure with a full queue, then release.
        fill_random();
        out_ready = 1'b1; mem_ready = 1'b1;
        do_reset();
        out_ready = 1'b0;
        repeat (6) cycle();
        for (int n = 0; n < 10; n++) begin
            cycle();
            chk("full_req_low", {31'b0, s_req}, 32'd0);
            chk("full_valid", {31'b0, s_valid}, 32'd1);
        end
        out_ready = 1'b1;
        base = pops;
        cnt = 0;
        while (pops - base < 6 && cnt < 30) begin
            cycle();
            cnt++;
        end
        chk("release_pops", {31'b0, (pops - base >= 6)}, 32'd1);

        // Reset mid-stream with three parcels queued.
        fill_random();
        mem[0] = 32'h45054501;
        out_ready = 1'b1;
        do_reset();
        out_ready = 1'b0;
        repeat (6) cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_mid_valid", {31'b0, s_valid}, 32'd0);
        chk("rst_mid_req", {31'b0, s_req}, 32'd1);
        chk("rst_mid_addr", s_addr, 32'h0);
        cycle();
        chk("rst_mid_valid2", {31'b0, s_valid}, 32'd0);
        out_ready = 1'b1;
        log_base = pops;
        cnt = 0;
        while (pops - log_base < 1 && cnt < 10) begin
            cycle();
            cnt++;
        end
        chk("rst_mid_pc", lp_pc[0], 32'h0);
        chk("rst_mid_inst", lp_inst[0], 32'h00004501);

        // Steady-state all-32-bit stream: at least one instruction per 2 cycles.
        for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
        do_reset();
        repeat (6) cycle();
        base = pops;
        repeat (40) cycle();
        chk("thru32_min", {31'b0, (pops - base >= 20)}, 32'd1);

        // Randomized traffic against the reference PC walk.
        fill_random();
        do_reset();
        base = pops;
        for (int n = 0; n < 3000; n++) begin
            mem_ready   = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 49) == 0);
            redirect_pc = {24'h0, 8'($urandom_range(0, 255))};
            rst         = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        redirect = 1'b0;
        chk("random_progress", {31'b0, (pops - base > 500)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
